// File: rtl/vip_axi4_pkg.sv
// Shared AXI4 VIP types: configuration, burst/size encodings, read-tracker
// error bit map and the tracking-entry layout.
package vip_axi4_pkg;

  typedef struct packed {
    int VIP_AXI4_ID_WIDTH_P;
    int VIP_AXI4_ADDR_WIDTH_P;
    int VIP_AXI4_DATA_WIDTH_P;
  } vip_axi4_cfg_t;

  // Fallback widths, used when a configuration field is left at zero.
  localparam int VIP_AXI4_ID_WIDTH_DEF_C   = 4;
  localparam int VIP_AXI4_ADDR_WIDTH_DEF_C = 32;
  localparam int VIP_AXI4_DATA_WIDTH_DEF_C = 64;

  // Entry storage is sized for the largest supported id and table depth.
  localparam int VIP_AXI4_ID_WIDTH_MAX_C  = 32;
  localparam int VIP_AXI4_AGE_WIDTH_MAX_C = 6;

  typedef enum logic [1:0] {
    VIP_AXI4_BURST_FIXED = 2'b00,
    VIP_AXI4_BURST_INCR  = 2'b01,
    VIP_AXI4_BURST_WRAP  = 2'b10,
    VIP_AXI4_BURST_RSVD  = 2'b11
  } vip_axi4_burst_t;

  typedef enum logic [2:0] {
    VIP_AXI4_SIZE_1B   = 3'd0,
    VIP_AXI4_SIZE_2B   = 3'd1,
    VIP_AXI4_SIZE_4B   = 3'd2,
    VIP_AXI4_SIZE_8B   = 3'd3,
    VIP_AXI4_SIZE_16B  = 3'd4,
    VIP_AXI4_SIZE_32B  = 3'd5,
    VIP_AXI4_SIZE_64B  = 3'd6,
    VIP_AXI4_SIZE_128B = 3'd7
  } vip_axi4_size_t;

  localparam int VIP_AXI4_RD_ERR_AR_OVERFLOW_C    = 0;
  localparam int VIP_AXI4_RD_ERR_AR_4K_C          = 1;
  localparam int VIP_AXI4_RD_ERR_AR_BURST_C       = 2;
  localparam int VIP_AXI4_RD_ERR_AR_WRAPLEN_C     = 3;
  localparam int VIP_AXI4_RD_ERR_AR_SIZE_C        = 4;
  localparam int VIP_AXI4_RD_ERR_R_UNEXP_ID_C     = 5;
  localparam int VIP_AXI4_RD_ERR_R_EARLY_LAST_C   = 6;
  localparam int VIP_AXI4_RD_ERR_R_MISSING_LAST_C = 7;
  localparam int VIP_AXI4_RD_ERR_TIMEOUT_C        = 8;
  localparam int VIP_AXI4_RD_ERR_WIDTH_C          = 9;

  typedef struct packed {
    logic                                valid;
    logic [VIP_AXI4_ID_WIDTH_MAX_C-1:0]  id;
    logic [8:0]                          remaining;
    logic [VIP_AXI4_AGE_WIDTH_MAX_C-1:0] age;
  } vip_axi4_rd_entry_t;

  function automatic int vip_axi4_cfg_width(input int w, input int def);
    return (w > 0) ? w : def;
  endfunction

endpackage

// File: rtl/vip_axi4_rd_ar_checker.sv
// Combinational legality checks on an AR (or AW) request: 4 KB crossing,
// reserved burst type, WRAP length/alignment and size against the data bus.
module vip_axi4_rd_ar_checker
  import vip_axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              err_4k,
  output logic              err_burst,
  output logic              err_wraplen,
  output logic              err_size
);

  localparam int EXT_W = ADDR_W + 8;

  logic [EXT_W-1:0]  start_ext;
  logic [EXT_W-1:0]  len_ext;
  logic [EXT_W-1:0]  end_ext;
  logic [ADDR_W-1:0] align_mask;
  logic              is_incr;
  logic              is_wrap;
  logic              wrap_len_ok;

  always_comb begin
    start_ext   = {8'b0, araddr};
    // Address of the first byte of the last beat; widened so it cannot wrap.
    len_ext     = {{(EXT_W-8){1'b0}}, arlen} << arsize;
    end_ext     = start_ext + len_ext;
    align_mask  = (ADDR_W'(1) << arsize) - ADDR_W'(1);
    is_incr     = (arburst == VIP_AXI4_BURST_INCR);
    is_wrap     = (arburst == VIP_AXI4_BURST_WRAP);
    wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);

    err_4k      = is_incr && (end_ext[EXT_W-1:12] != start_ext[EXT_W-1:12]);
    err_burst   = (arburst == VIP_AXI4_BURST_RSVD);
    err_wraplen = is_wrap && (!wrap_len_ok || ((araddr & align_mask) != '0));
    err_size    = (32'd8 << arsize) > 32'(DATA_W);
  end

endmodule

// File: rtl/vip_axi4_rd_tracker.sv
// Passive AXI4 read-channel tracker: records outstanding bursts per id and
// reports protocol errors as registered pulses, sticky flags and a counter.
module vip_axi4_rd_tracker
  import vip_axi4_pkg::*;
#(
  parameter vip_axi4_cfg_t CFG_P = '{default: '0},
  parameter int MAX_OUTSTANDING_P = 8,
  parameter int TIMEOUT_P         = 1024,
  parameter int CNT_WIDTH_P       = 16,
  localparam int ID_W   = vip_axi4_cfg_width(CFG_P.VIP_AXI4_ID_WIDTH_P, VIP_AXI4_ID_WIDTH_DEF_C),
  localparam int ADDR_W = vip_axi4_cfg_width(CFG_P.VIP_AXI4_ADDR_WIDTH_P, VIP_AXI4_ADDR_WIDTH_DEF_C),
  localparam int DATA_W = vip_axi4_cfg_width(CFG_P.VIP_AXI4_DATA_WIDTH_P, VIP_AXI4_DATA_WIDTH_DEF_C),
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING_P + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [ID_W-1:0]                    arid,
  input  logic [ADDR_W-1:0]                  araddr,
  input  logic [7:0]                         arlen,
  input  logic [2:0]                         arsize,
  input  logic [1:0]                         arburst,
  input  logic                               arvalid,
  input  logic                               arready,
  input  logic [ID_W-1:0]                    rid,
  input  logic                               rlast,
  input  logic                               rvalid,
  input  logic                               rready,
  output logic [VIP_AXI4_RD_ERR_WIDTH_C-1:0] err_pulse,
  output logic [VIP_AXI4_RD_ERR_WIDTH_C-1:0] err_sticky,
  output logic [CNT_WIDTH_P-1:0]             err_cnt,
  output logic [OUT_W-1:0]                   outstanding
);

  localparam int IDX_W = $clog2(MAX_OUTSTANDING_P);
  localparam int TMO_W = $clog2(TIMEOUT_P + 1);
  localparam int ERR_W = VIP_AXI4_RD_ERR_WIDTH_C;
  localparam int AGE_W = VIP_AXI4_AGE_WIDTH_MAX_C;
  localparam int IDM_W = VIP_AXI4_ID_WIDTH_MAX_C;

  vip_axi4_rd_entry_t     tbl_q [MAX_OUTSTANDING_P];
  vip_axi4_rd_entry_t     tbl_d [MAX_OUTSTANDING_P];
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [ERR_W-1:0]       err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]       err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH_P-1:0] err_cnt_q, err_cnt_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;

  logic             ar_hs, r_hs;
  logic [IDM_W-1:0] arid_ext, rid_ext;
  logic             tgt_hit, free_hit;
  logic [IDX_W-1:0] tgt_idx, free_idx;
  logic [AGE_W-1:0] new_age;
  logic             alloc, retire, rem_dec;
  logic             r_unexp, r_early, r_missing;
  logic             tmo_fire;
  logic             chk_4k, chk_burst, chk_wraplen, chk_size;

  // A transfer happens on a channel only in a cycle where valid and ready are
  // both high; the tracker never drives either signal.
  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  assign arid_ext = IDM_W'(arid);
  assign rid_ext  = IDM_W'(rid);

  vip_axi4_rd_ar_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ar_checker (
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .err_4k      (chk_4k),
    .err_burst   (chk_burst),
    .err_wraplen (chk_wraplen),
    .err_size    (chk_size)
  );

  // R target is the oldest burst of rid; new AR takes the lowest free slot.
  always_comb begin
    tgt_hit  = 1'b0;
    tgt_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = 0; i < MAX_OUTSTANDING_P; i++) begin
      if (tbl_q[i].valid && (tbl_q[i].id == rid_ext) && (tbl_q[i].age == '0)) begin
        tgt_hit = 1'b1;
        tgt_idx = IDX_W'(i);
      end
      if (!tbl_q[i].valid && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    r_unexp   = 1'b0;
    r_early   = 1'b0;
    r_missing = 1'b0;
    retire    = 1'b0;
    rem_dec   = 1'b0;
    if (r_hs) begin
      if (!tgt_hit) begin
        r_unexp = 1'b1;
      end else if (rlast && (tbl_q[tgt_idx].remaining > 9'd1)) begin
        r_early = 1'b1;
        retire  = 1'b1;
      end else if (!rlast && (tbl_q[tgt_idx].remaining == 9'd1)) begin
        r_missing = 1'b1;
        retire    = 1'b1;
      end else if (tbl_q[tgt_idx].remaining == 9'd1) begin
        retire = 1'b1;
      end else begin
        rem_dec = 1'b1;
      end
    end
  end

  always_comb begin
    alloc   = ar_hs && free_hit;
    new_age = '0;
    for (int i = 0; i < MAX_OUTSTANDING_P; i++) begin
      if (tbl_q[i].valid && (tbl_q[i].id == arid_ext) && !(retire && (tgt_idx == IDX_W'(i)))) begin
        new_age = new_age + AGE_W'(1);
      end
    end

    for (int i = 0; i < MAX_OUTSTANDING_P; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (rem_dec) begin
      tbl_d[tgt_idx].remaining = tbl_q[tgt_idx].remaining - 9'd1;
    end
    if (retire) begin
      for (int i = 0; i < MAX_OUTSTANDING_P; i++) begin
        if (tbl_q[i].valid && (tbl_q[i].id == rid_ext) && (IDX_W'(i) != tgt_idx)) begin
          tbl_d[i].age = tbl_q[i].age - AGE_W'(1);
        end
      end
      tbl_d[tgt_idx].valid = 1'b0;
    end
    // free_idx was free in tbl_q, so it never collides with the retiring slot.
    if (alloc) begin
      tbl_d[free_idx].valid     = 1'b1;
      tbl_d[free_idx].id        = arid_ext;
      tbl_d[free_idx].remaining = {1'b0, arlen} + 9'd1;
      tbl_d[free_idx].age       = new_age;
    end
    outstanding_d = outstanding_q + OUT_W'(alloc) - OUT_W'(retire);
  end

  always_comb begin
    tmo_fire = 1'b0;
    if (clr || r_hs || (outstanding_q == '0)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_P)) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      tmo_fire  = (tmo_cnt_q == TMO_W'(TIMEOUT_P - 1));
    end
  end

  always_comb begin
    err_pulse_d = '0;
    err_pulse_d[VIP_AXI4_RD_ERR_AR_OVERFLOW_C]    = ar_hs && !free_hit;
    err_pulse_d[VIP_AXI4_RD_ERR_AR_4K_C]          = ar_hs && chk_4k;
    err_pulse_d[VIP_AXI4_RD_ERR_AR_BURST_C]       = ar_hs && chk_burst;
    err_pulse_d[VIP_AXI4_RD_ERR_AR_WRAPLEN_C]     = ar_hs && chk_wraplen;
    err_pulse_d[VIP_AXI4_RD_ERR_AR_SIZE_C]        = ar_hs && chk_size;
    err_pulse_d[VIP_AXI4_RD_ERR_R_UNEXP_ID_C]     = r_unexp;
    err_pulse_d[VIP_AXI4_RD_ERR_R_EARLY_LAST_C]   = r_early;
    err_pulse_d[VIP_AXI4_RD_ERR_R_MISSING_LAST_C] = r_missing;
    err_pulse_d[VIP_AXI4_RD_ERR_TIMEOUT_C]        = tmo_fire;

    err_sticky_d = clr ? '0 : (err_sticky_q | err_pulse_d);
    err_cnt_d    = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if ((err_pulse_d != '0) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH_P'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING_P; i++) begin
        tbl_q[i] <= '0;
      end
      tmo_cnt_q     <= '0;
      err_pulse_q   <= '0;
      err_sticky_q  <= '0;
      err_cnt_q     <= '0;
      outstanding_q <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING_P; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      tmo_cnt_q     <= tmo_cnt_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_cnt_q     <= err_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign err_cnt     = err_cnt_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_vip_axi4_rd_tracker.sv
// Directed scoreboard bench for vip_axi4_rd_tracker: each driven cycle queues
// its expected registered outputs; a monitor pops and compares after each edge.
module tb_vip_axi4_rd_tracker;
  import vip_axi4_pkg::*;

  localparam vip_axi4_cfg_t CFG = '{VIP_AXI4_ID_WIDTH_P: 4, VIP_AXI4_ADDR_WIDTH_P: 32,
                                    VIP_AXI4_DATA_WIDTH_P: 64};
  localparam int EW = 9 + 9 + 4 + 16;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10, B_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  arid = '0, rid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready = 1'b0;
  logic [8:0]  err_pulse, err_sticky;
  logic [15:0] err_cnt;
  logic [3:0]  outstanding;

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [8:0]    m_sticky = '0;
  logic [15:0]   m_cnt = '0;

  always #5 clk = ~clk;

  vip_axi4_rd_tracker #(
    .CFG_P             (CFG),
    .MAX_OUTSTANDING_P (8),
    .TIMEOUT_P         (16),
    .CNT_WIDTH_P       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt),
    .outstanding (outstanding)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One cycle of stimulus plus the outputs expected after the following edge.
  task automatic drive(input logic av, input logic ardy, input logic [3:0] id,
                       input logic [31:0] addr, input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu, input logic rv, input logic rrdy,
                       input logic [3:0] ri, input logic rl, input logic c,
                       input logic [8:0] ep, input logic [3:0] eo);
    @(negedge clk);
    arvalid = av; arready = ardy; arid = id; araddr = addr; arlen = len;
    arsize = sz; arburst = bu; rvalid = rv; rready = rrdy; rid = ri; rlast = rl;
    clr = c;
    if (c) begin
      m_sticky = '0;
      m_cnt    = '0;
    end else begin
      m_sticky = m_sticky | ep;
      if ((ep != '0) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    end
    exp_q.push_back({ep, m_sticky, eo, m_cnt});
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] sz, input logic [1:0] bu, input logic [8:0] ep,
                    input logic [3:0] eo);
    drive(1'b1, 1'b1, id, addr, len, sz, bu, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, ep, eo);
  endtask

  task automatic rb(input logic [3:0] ri, input logic rl, input logic [8:0] ep,
                    input logic [3:0] eo);
    drive(1'b0, 1'b1, 4'd0, 32'd0, 8'd0, 3'd0, B_INCR, 1'b1, 1'b1, ri, rl, 1'b0, ep, eo);
  endtask

  task automatic arr(input logic [3:0] id, input logic [7:0] len, input logic [3:0] ri,
                     input logic rl, input logic [8:0] ep, input logic [3:0] eo);
    drive(1'b1, 1'b1, id, 32'd0, len, 3'd2, B_INCR, 1'b1, 1'b1, ri, rl, 1'b0, ep, eo);
  endtask

  task automatic idle(input logic [8:0] ep, input logic [3:0] eo);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 8'd0, 3'd0, B_INCR, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ep, eo);
  endtask

  task automatic clr_cyc(input logic [3:0] eo);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 8'd0, 3'd0, B_INCR, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 9'd0, eo);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, "_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_outstanding"}, 32'(outstanding), 32'd0);
  endtask

  always @(posedge clk) begin : monitor
    logic [EW-1:0] e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("err_pulse", 32'(err_pulse), 32'(e[37:29]));
      check("err_sticky", 32'(err_sticky), 32'(e[28:20]));
      check("outstanding", 32'(outstanding), 32'(e[19:16]));
      check("err_cnt", 32'(err_cnt), 32'(e[15:0]));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean 4-beat INCR burst, then handshake-less valids.
    ar(4'd3, 32'h1000, 8'd3, 3'd2, B_INCR, 9'h000, 4'd1);
    rb(4'd3, 1'b0, 9'h000, 4'd1);
    rb(4'd3, 1'b0, 9'h000, 4'd1);
    rb(4'd3, 1'b0, 9'h000, 4'd1);
    rb(4'd3, 1'b1, 9'h000, 4'd0);
    drive(1'b1, 1'b0, 4'd4, 32'd0, 8'd0, 3'd2, B_RSVD, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 9'h000, 4'd0);

    // Two bursts on one id complete in order.
    ar(4'd5, 32'h2000, 8'd1, 3'd2, B_INCR, 9'h000, 4'd1);
    ar(4'd5, 32'h3000, 8'd0, 3'd2, B_INCR, 9'h000, 4'd2);
    rb(4'd5, 1'b0, 9'h000, 4'd2);
    rb(4'd5, 1'b1, 9'h000, 4'd1);
    rb(4'd5, 1'b1, 9'h000, 4'd0);

    // AR legality checks; every burst is still tracked.
    ar(4'd1, 32'hFF8, 8'd3, 3'd3, B_INCR, 9'h002, 4'd1);
    rb(4'd1, 1'b0, 9'h000, 4'd1);
    rb(4'd1, 1'b0, 9'h000, 4'd1);
    rb(4'd1, 1'b0, 9'h000, 4'd1);
    rb(4'd1, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'hFF8, 8'd3, 3'd3, B_FIXED, 9'h000, 4'd1);
    for (int i = 0; i < 3; i++) rb(4'd2, 1'b0, 9'h000, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'h0, 8'd0, 3'd2, B_RSVD, 9'h004, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'h0, 8'd2, 3'd2, B_WRAP, 9'h008, 4'd1);
    rb(4'd2, 1'b0, 9'h000, 4'd1);
    rb(4'd2, 1'b0, 9'h000, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'h2, 8'd3, 3'd2, B_WRAP, 9'h008, 4'd1);
    for (int i = 0; i < 3; i++) rb(4'd2, 1'b0, 9'h000, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'h10, 8'd3, 3'd2, B_WRAP, 9'h000, 4'd1);
    for (int i = 0; i < 3; i++) rb(4'd2, 1'b0, 9'h000, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'h0, 8'd0, 3'd4, B_INCR, 9'h010, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);
    ar(4'd2, 32'h0, 8'd0, 3'd7, B_RSVD, 9'h014, 4'd1);
    rb(4'd2, 1'b1, 9'h000, 4'd0);

    // Same-cycle retire and allocate on one id; new entry is never the target.
    ar(4'd4, 32'h0, 8'd0, 3'd2, B_INCR, 9'h000, 4'd1);
    arr(4'd4, 8'd0, 4'd4, 1'b1, 9'h000, 4'd1);
    rb(4'd4, 1'b1, 9'h000, 4'd0);
    arr(4'd6, 8'd0, 4'd6, 1'b1, 9'h020, 4'd1);
    rb(4'd6, 1'b1, 9'h000, 4'd0);

    // Fill the table, overflow, overflow with a same-cycle retire, then drain.
    for (int i = 0; i < 8; i++) ar(4'(i), 32'(i * 256), 8'd0, 3'd2, B_INCR, 9'h000, 4'(i + 1));
    ar(4'd8, 32'h0, 8'd0, 3'd2, B_INCR, 9'h001, 4'd8);
    arr(4'd9, 8'd0, 4'd0, 1'b1, 9'h001, 4'd7);
    ar(4'd9, 32'h0, 8'd0, 3'd2, B_INCR, 9'h000, 4'd8);
    for (int i = 1; i < 8; i++) rb(4'(i), 1'b1, 9'h000, 4'(8 - i));
    rb(4'd9, 1'b1, 9'h000, 4'd0);

    // R-side errors, counted from a clear.
    clr_cyc(4'd0);
    ar(4'd1, 32'h0, 8'd3, 3'd2, B_INCR, 9'h000, 4'd1);
    rb(4'd1, 1'b0, 9'h000, 4'd1);
    rb(4'd1, 1'b1, 9'h040, 4'd0);
    ar(4'd2, 32'h0, 8'd0, 3'd2, B_INCR, 9'h000, 4'd1);
    rb(4'd2, 1'b0, 9'h080, 4'd0);
    rb(4'd7, 1'b1, 9'h020, 4'd0);

    // Reset mid-burst: the remaining beat is unexpected afterwards.
    ar(4'd2, 32'h0, 8'd3, 3'd2, B_INCR, 9'h000, 4'd1);
    rb(4'd2, 1'b0, 9'h000, 4'd1);
    @(negedge clk);
    rst = 1'b1; arvalid = 1'b0; rvalid = 1'b0; clr = 1'b0;
    #1;
    check_reset_state("midrst");
    m_sticky = '0;
    m_cnt    = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    rb(4'd2, 1'b1, 9'h020, 4'd0);

    // Timeout fires once, holds, and re-arms after a clear.
    ar(4'd3, 32'h0, 8'd0, 3'd2, B_INCR, 9'h000, 4'd1);
    for (int k = 1; k <= 20; k++) idle((k == 16) ? 9'h100 : 9'h000, 4'd1);
    clr_cyc(4'd1);
    for (int k = 1; k <= 16; k++) idle((k == 16) ? 9'h100 : 9'h000, 4'd1);
    rb(4'd3, 1'b1, 9'h000, 4'd0);
    idle(9'h000, 4'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
